add_share_arb: RTL and testbench
================================

Name: add_share_arb

Overview:
- Round-robin arbiter that time-shares one registered 16-bit adder (17-bit sum, one-cycle latency) among N_REQ requesters in the PID datapath, e.g. error, integral and output accumulation paths.
- Accepts one operand pair per cycle over a valid/ready handshake and drives the shared adder's inputs.
- Tracks the in-flight request and returns the sum to the originating requester one cycle later.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- DW, 16, operand width; the sum is DW+1 bits.
- IDW, 2, requester index width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arb_en  in  1  grant enable; low blocks new grants.
- req_valid  in  N_REQ  per-requester operand-pair valid.
- req_a  in  N_REQ*DW  operand A, requester i at bits [i*DW +: DW].
- req_b  in  N_REQ*DW  operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; handshake when valid and ready are both high.
- add_a  out  DW  to the shared adder input a.
- add_b  out  DW  to the shared adder input b.
- add_s  in  DW+1  from the shared adder output s; registered, valid one cycle after the operands.
- rsp_valid  out  N_REQ  one-hot result strobe.
- rsp_sum  out  DW+1  result.
- rsp_id  out  IDW  index of the requester owning rsp_sum.
- busy  out  1  high while a result is in flight.

Behaviour:
- Reset is synchronous and active-high. The shared adder's rst_n is tied to ~rst at the top level.
- State: rr_ptr (IDW bits), fl_vld (1), fl_id (IDW). Reset values are rr_ptr=0, fl_vld=0, fl_id=0.
- Output values during and after reset:
  - req_ready=0, rsp_valid=0, busy=0.
  - rsp_sum=0 while rsp_valid is low.
  - rsp_id=0, add_a=0, add_b=0.
- Grant selection is combinational each cycle:
  - No grant while rst=1 or arb_en=0.
  - Otherwise search req_valid from rr_ptr upward, modulo N_REQ; the first set bit g wins and req_ready[g]=1.
  - At most one req_ready bit is high. If req_valid is all zero, req_ready=0.
- Operand mux:
  - With a grant: add_a=req_a[g], add_b=req_b[g].
  - With no grant: add_a=0, add_b=0 (deterministic, low toggle).
- On each clock edge with a grant:
  - rr_ptr <= (g+1) mod N_REQ.
  - fl_vld <= 1, fl_id <= g.
- On each clock edge with no grant: fl_vld <= 0; rr_ptr holds.
- Response, combinational from state:
  - rsp_valid[fl_id] = fl_vld, all other bits 0.
  - rsp_sum = add_s when fl_vld=1, else 0.
  - rsp_id = fl_id; busy = fl_vld.
- Latency and throughput:
  - Handshake in cycle t gives rsp_valid in cycle t+1. Exactly one result per accepted request, in issue order.
  - Full throughput of one grant per cycle; back-to-back grants pipeline through the adder.
- No response backpressure: requesters must consume rsp_valid in the cycle it is asserted.
- Arithmetic: the unsigned DW+1-bit sum passes through with no truncation or saturation. Max 0xFFFF+0xFFFF = 0x1FFFE.
- Requester protocol (bench assertion, not checked in RTL): once req_valid[i] rises, it and req_a[i]/req_b[i] stay stable until req_ready[i].
- Boundary conditions:
  - All requesters valid continuously: grants 0,1,2,...,N_REQ-1,0,...
  - A requester that is the only one valid is granted every cycle.
  - rr_ptr wraps from N_REQ-1 to 0.
  - arb_en falling with a result in flight: that result is still delivered next cycle; no further grants.
  - arb_en rising: grants resume the same cycle from the held rr_ptr.
  - rst asserted while fl_vld=1: the in-flight result is dropped; no rsp_valid in the following cycle.
  - Grant and response in the same cycle are independent; both occur.

Optional Feature:
- Macro: ADD_SHARE_ARB_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority. If req_valid[0]=1 and arb_en=1, g=0 regardless of rr_ptr, and rr_ptr is NOT updated. Remaining requesters round-robin among themselves as above when req_valid[0]=0.
- Undefined: pure round-robin over all requesters.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then all req_valid=0 -> req_ready=0, rsp_valid=0, busy=0, add_a=add_b=0 every cycle.
- Single request: req_valid=4'b0100, a=0x1234, b=0x0F0F -> req_ready=4'b0100 in cycle t; in cycle t+1 rsp_valid=4'b0100, rsp_id=2, rsp_sum=0x02143.
- Full contention: req_valid=4'b1111 held 8 cycles, operands a=i, b=0x100*i -> grant order 0,1,2,3,0,1,2,3; each rsp_sum=0x101*i one cycle after its grant.
- Overflow: a=0xFFFF, b=0xFFFF -> rsp_sum=0x1FFFE; a=0xFFFF, b=0x0001 -> 0x10000.
- Enable/reset mid-flight:
  - arb_en drops the cycle after a grant -> that response delivered, no new grants while low; grants resume from the correct rr_ptr when high.
  - rst pulses with fl_vld=1 -> no rsp_valid afterwards, rr_ptr=0.
- With ADD_SHARE_ARB_PRIO0_EN: req_valid=4'b1111 for 4 cycles -> grants 0,0,0,0. Then drop bit 0 -> grants 1,2,3,1.

Source files
------------

// File: rtl/add_share_arb.sv
// -----------------------------------------------------------------------------
// add_share_arb
//
// Purpose
//   Round-robin arbiter that time-shares one external registered adder
//   (DW-bit operands, DW+1-bit sum, one-cycle latency) among N_REQ requesters
//   in the PID datapath. One operand pair is accepted per cycle. The winner's
//   operands are steered onto the adder inputs. The sum coming back one cycle
//   later is tagged with the originating requester and strobed out.
//
// Handshake
//   req_valid[i] and req_ready[i] form a valid/ready pair. A transfer happens
//   in any cycle where both are high. req_ready is at most one-hot and is a
//   combinational function of req_valid, arb_en, rst and the round-robin
//   pointer. A requester must hold valid and its operands stable until it sees
//   ready. Responses have no backpressure: rsp_valid[i] is a single-cycle
//   strobe that must be consumed in the cycle it is asserted.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   DW     operand width; the sum is DW+1 bits
//   IDW    requester index width, equal to clog2(N_REQ)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   arb_en     in   grant enable; low blocks new grants
//   req_valid  in   [N_REQ]      per-requester operand-pair valid
//   req_a      in   [N_REQ*DW]   operand A, requester i at [i*DW +: DW]
//   req_b      in   [N_REQ*DW]   operand B, same packing
//   req_ready  out  [N_REQ]      one-hot grant
//   add_a      out  [DW]         to shared adder input a
//   add_b      out  [DW]         to shared adder input b
//   add_s      in   [DW+1]       registered sum from the shared adder
//   rsp_valid  out  [N_REQ]      one-hot result strobe
//   rsp_sum    out  [DW+1]       result, zero when no result is presented
//   rsp_id     out  [IDW]        index of the requester owning rsp_sum
//   busy       out  1            high while a result is in flight
//
// Configuration
//   ADD_SHARE_ARB_PRIO0_EN  when defined, requester 0 has fixed absolute
//                           priority and its grants leave the round-robin
//                           pointer untouched. Undefined: pure round-robin.
//
// The shared adder's active-low reset is expected to be tied to ~rst at the
// level that instantiates both this arbiter and the adder.
// -----------------------------------------------------------------------------
module add_share_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       add_a,
  output logic [DW-1:0]       add_b,
  input  logic [DW:0]         add_s,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW:0]         rsp_sum,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;   // first requester searched next cycle
  logic           fl_vld_q, fl_vld_d;   // a sum is emerging from the adder
  logic [IDW-1:0] fl_id_q,  fl_id_d;    // owner of the emerging sum

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic           prio_hit;    // grant taken by the fixed-priority requester
  logic [IDW:0]   pos;         // one extra bit so rr_ptr + k cannot overflow

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    prio_hit  = 1'b0;
    pos       = '0;
    if (!rst && arb_en) begin
`ifdef ADD_SHARE_ARB_PRIO0_EN
      prio_hit = req_valid[0];
`else
      prio_hit = 1'b0;
`endif
      if (prio_hit) begin
        grant_vld = 1'b1;
        grant_idx = '0;
      end else begin
        // Walk N_REQ slots starting at rr_ptr, wrapping modulo N_REQ; the
        // first valid requester found wins.
        for (int k = 0; k < N_REQ; k++) begin
          pos = {1'b0, rr_ptr_q} + (IDW+1)'(k);
          if (pos >= (IDW+1)'(N_REQ)) begin
            pos = pos - (IDW+1)'(N_REQ);
          end
          if (!grant_vld && req_valid[pos[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = pos[IDW-1:0];
          end
        end
      end
    end
  end

  // One-hot ready decoded from the winning index.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vld && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand mux: idle cycles drive zero so the adder inputs do not toggle.
  // ---------------------------------------------------------------------------
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (grant_vld) begin
      add_a = req_a[grant_idx*DW +: DW];
      add_b = req_b[grant_idx*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    fl_vld_d = grant_vld;
    fl_id_d  = fl_id_q;
    if (grant_vld) begin
      fl_id_d = grant_idx;
      // A fixed-priority grant does not consume a round-robin turn.
      if (!prio_hit) begin
        if (grant_idx == IDW'(N_REQ-1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_idx + IDW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      fl_vld_q <= 1'b0;
      fl_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      fl_vld_q <= fl_vld_d;
      fl_id_q  <= fl_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path. Outputs are forced quiet while rst is high so a result in
  // flight when reset arrives is never presented, not even in the reset cycle.
  // ---------------------------------------------------------------------------
  logic rsp_live;
  assign rsp_live = fl_vld_q && !rst;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_live && (fl_id_q == IDW'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_sum = rsp_live ? add_s : '0;
  assign rsp_id  = rst ? '0 : fl_id_q;
  assign busy    = rsp_live;

endmodule

// File: tb/tb_add_share_arb.sv
// -----------------------------------------------------------------------------
// tb_add_share_arb
//
// Directed bench for add_share_arb with N_REQ=4, DW=16. Includes a behavioural
// registered adder (sum valid one cycle after the operands, reset on rst).
// Each step drives one cycle of inputs shortly after the rising edge, then
// checks the combinational grant/operand outputs and the response from the
// previous cycle's grant against hand-computed values.
// -----------------------------------------------------------------------------
module tb_add_share_arb;

  localparam int N_REQ = 4;
  localparam int DW    = 16;
  localparam int IDW   = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                arb_en;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       add_a;
  logic [DW-1:0]       add_b;
  logic [DW:0]         add_s;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW:0]         rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  add_share_arb #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Shared adder model: registered, reset by rst (its rst_n is ~rst).
  always @(posedge clk) begin
    if (rst) add_s <= '0;
    else     add_s <= {1'b0, add_a} + {1'b0, add_b};
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_op(input int i, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // One cycle: drive inputs after the edge, check before the next edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [3:0] v, input logic [3:0] exp_rdy,
                      input logic [3:0] exp_rv, input logic [1:0] exp_id,
                      input logic [16:0] exp_sum, input logic [15:0] exp_a,
                      input logic [15:0] exp_b);
    @(posedge clk);
    #2;
    rst       = r;
    arb_en    = en;
    req_valid = v;
    #1;
    check_eq({tag, ".ready"},     32'(req_ready), 32'(exp_rdy));
    check_eq({tag, ".add_a"},     32'(add_a),     32'(exp_a));
    check_eq({tag, ".add_b"},     32'(add_b),     32'(exp_b));
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_rv));
    check_eq({tag, ".rsp_sum"},   32'(rsp_sum),   32'(exp_sum));
    check_eq({tag, ".busy"},      32'(busy),      32'(|exp_rv));
    if (exp_rv != 4'b0000 || r) begin
      check_eq({tag, ".rsp_id"},  32'(rsp_id),    32'(exp_id));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [16:0] cont_sum [4];
  int g, p;

  initial begin
    rst       = 1'b1;
    arb_en    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    cont_sum  = '{17'h00000, 17'h00101, 17'h00202, 17'h00303};
    @(posedge clk);

    // Reset: valid requests are ignored, everything quiet.
    for (int i = 0; i < 3; i++)
      step("reset", 1, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 17'h0, 16'h0, 16'h0);
    for (int i = 0; i < 2; i++)
      step("idle", 0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 17'h0, 16'h0, 16'h0);

    // Single request from requester 2.
    set_op(2, 16'h1234, 16'h0F0F);
    step("single",     0, 1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 17'h0,     16'h1234, 16'h0F0F);
    step("single_rsp", 0, 1, 4'b0000, 4'b0000, 4'b0100, 2'd2, 17'h02143, 16'h0,    16'h0);
    step("rst_pulse",  1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 17'h0,     16'h0,    16'h0);

    // Full contention from rr_ptr=0: grants 0,1,2,3,0,1,2,3 with pipelined sums.
    for (int i = 0; i < 4; i++) set_op(i, 16'(i), 16'(i * 16'h0100));
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      p = (k + 3) % 4;
      step("contend", 0, 1, 4'b1111, 4'(1 << g),
           (k == 0) ? 4'b0000 : 4'(1 << p), 2'(p),
           (k == 0) ? 17'h0 : cont_sum[p], 16'(g), 16'(g * 16'h0100));
    end
    step("contend_tail", 0, 1, 4'b0000, 4'b0000, 4'b1000, 2'd3, 17'h00303, 16'h0, 16'h0);

    // Overflow: no truncation of the carry bit.
    set_op(1, 16'hFFFF, 16'hFFFF);
    set_op(2, 16'hFFFF, 16'h0001);
    step("ovf0", 0, 1, 4'b0110, 4'b0010, 4'b0000, 2'd0, 17'h0,     16'hFFFF, 16'hFFFF);
    step("ovf1", 0, 1, 4'b0100, 4'b0100, 4'b0010, 2'd1, 17'h1FFFE, 16'hFFFF, 16'h0001);
    step("ovf2", 0, 1, 4'b0000, 4'b0000, 4'b0100, 2'd2, 17'h10000, 16'h0,    16'h0);

    // arb_en drop with a result in flight, then resume from held rr_ptr=3.
    set_op(2, 16'h0011, 16'h0022);
    step("en_grant",   0, 1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 17'h0,     16'h0011, 16'h0022);
    step("en_low_rsp", 0, 0, 4'b1010, 4'b0000, 4'b0100, 2'd2, 17'h00033, 16'h0,    16'h0);
    step("en_low",     0, 0, 4'b1010, 4'b0000, 4'b0000, 2'd0, 17'h0,     16'h0,    16'h0);
    step("en_resume",  0, 1, 4'b1010, 4'b1000, 4'b0000, 2'd0, 17'h0,     16'h0003, 16'h0300);
    step("en_next",    0, 1, 4'b0010, 4'b0010, 4'b1000, 2'd3, 17'h00303, 16'hFFFF, 16'hFFFF);
    step("en_tail",    0, 1, 4'b0000, 4'b0000, 4'b0010, 2'd1, 17'h1FFFE, 16'h0,    16'h0);

    // Reset while a result is in flight: dropped, rr_ptr back to 0.
    step("rfl_grant",  0, 1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 17'h0,     16'h0011, 16'h0022);
    step("rfl_rst",    1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 17'h0,     16'h0,    16'h0);
    step("rfl_after",  0, 1, 4'b1010, 4'b0010, 4'b0000, 2'd0, 17'h0,     16'hFFFF, 16'hFFFF);
    step("rfl_after2", 0, 1, 4'b1000, 4'b1000, 4'b0010, 2'd1, 17'h1FFFE, 16'h0003, 16'h0300);
    step("rfl_after3", 0, 1, 4'b0000, 4'b0000, 4'b1000, 2'd3, 17'h00303, 16'h0,    16'h0);

    // Final contention from rr_ptr=0 with mixed operands.
    set_op(0, 16'h0011, 16'h0022);
`ifdef ADD_SHARE_ARB_PRIO0_EN
    step("prio0", 0, 1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 17'h0,     16'h0011, 16'h0022);
    step("prio1", 0, 1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 17'h00033, 16'h0011, 16'h0022);
    step("prio2", 0, 1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 17'h00033, 16'h0011, 16'h0022);
    step("prio3", 0, 1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 17'h00033, 16'h0011, 16'h0022);
    step("prr1",  0, 1, 4'b1110, 4'b0010, 4'b0001, 2'd0, 17'h00033, 16'hFFFF, 16'hFFFF);
    step("prr2",  0, 1, 4'b1110, 4'b0100, 4'b0010, 2'd1, 17'h1FFFE, 16'h0011, 16'h0022);
    step("prr3",  0, 1, 4'b1110, 4'b1000, 4'b0100, 2'd2, 17'h00033, 16'h0003, 16'h0300);
    step("prr4",  0, 1, 4'b1110, 4'b0010, 4'b1000, 2'd3, 17'h00303, 16'hFFFF, 16'hFFFF);
    step("prr_t", 0, 1, 4'b0000, 4'b0000, 4'b0010, 2'd1, 17'h1FFFE, 16'h0,    16'h0);
`else
    step("rr0",   0, 1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 17'h0,     16'h0011, 16'h0022);
    step("rr1",   0, 1, 4'b1111, 4'b0010, 4'b0001, 2'd0, 17'h00033, 16'hFFFF, 16'hFFFF);
    step("rr2",   0, 1, 4'b1111, 4'b0100, 4'b0010, 2'd1, 17'h1FFFE, 16'h0011, 16'h0022);
    step("rr3",   0, 1, 4'b1111, 4'b1000, 4'b0100, 2'd2, 17'h00033, 16'h0003, 16'h0300);
    step("rr_t",  0, 1, 4'b0000, 4'b0000, 4'b1000, 2'd3, 17'h00303, 16'h0,    16'h0);
`endif

    // -------------------------------------------------------------------------
    // Final report
    // -------------------------------------------------------------------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
